// File: rtl/mb_rtu_pkg.sv
// -----------------------------------------------------------------------------
// mb_rtu_pkg
// Shared definitions for the Modbus RTU master poll scheduler:
//   - one-hot FSM state encoding (6 bits)
//   - Modbus function-code constants
//   - default silent-gap / watchdog cycle counts (50 MHz, 9600 baud)
//   - saturating 16-bit increment helper
// -----------------------------------------------------------------------------
package mb_rtu_pkg;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_SELECT  = 6'b000010,
        ST_LAUNCH  = 6'b000100,
        ST_WAIT_TX = 6'b001000,
        ST_WAIT_RX = 6'b010000,
        ST_GAP     = 6'b100000
    } poll_state_e;

    localparam logic [7:0] FC_READ_HOLD   = 8'h03;
    localparam logic [7:0] FC_WRITE_MULTI = 8'h10;

    // 3.5 character times at 9600 baud, and 100 ms, both at 50 MHz
    localparam int unsigned DEF_GAP_CYCLES     = 32'd200000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd5000000;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mb_poll_table.sv
// -----------------------------------------------------------------------------
// mb_poll_table
// Poll-table register file. One synchronous write port driven by the host
// configuration strobe, one combinational read port addressed by the
// scheduler, and the packed vector of entry-enable bits.
// Ports:
//   clk, rst_n            clock, async active-low reset (clears every entry)
//   cfg_we/cfg_idx        write strobe and entry index
//   cfg_valid/fun/addr/num entry contents
//   rd_idx                read index
//   rd_fun/addr/num       contents of entry rd_idx
//   valid_vec             enable bit of every entry
// -----------------------------------------------------------------------------
module mb_poll_table #(
    parameter int ENTRIES = 4,
    parameter int IDX_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic               cfg_valid,
    input  logic [7:0]         cfg_fun,
    input  logic [15:0]        cfg_addr,
    input  logic [15:0]        cfg_num,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [7:0]         rd_fun,
    output logic [15:0]        rd_addr,
    output logic [15:0]        rd_num,
    output logic [ENTRIES-1:0] valid_vec
);

    logic [ENTRIES-1:0] valid_r;
    logic [7:0]         fun_r  [ENTRIES];
    logic [15:0]        addr_r [ENTRIES];
    logic [15:0]        num_r  [ENTRIES];

    // Table storage: cleared on reset, one entry written per cfg_we
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                fun_r[i]  <= 8'h00;
                addr_r[i] <= 16'h0000;
                num_r[i]  <= 16'h0000;
            end
        end else if (cfg_we) begin
            valid_r[cfg_idx] <= cfg_valid;
            fun_r[cfg_idx]   <= cfg_fun;
            addr_r[cfg_idx]  <= cfg_addr;
            num_r[cfg_idx]   <= cfg_num;
        end
    end

    assign rd_fun    = fun_r[rd_idx];
    assign rd_addr   = addr_r[rd_idx];
    assign rd_num    = num_r[rd_idx];
    assign valid_vec = valid_r;

endmodule

// File: rtl/mb_rtu_poll_sched.sv
// -----------------------------------------------------------------------------
// mb_rtu_poll_sched
// Modbus RTU master poll scheduler. Walks the poll table round-robin, launches
// one request per valid entry towards the RTU transmitter, waits for TX done
// and then for the slave response (or a watchdog timeout), and enforces the
// RTU silent gap before the next launch.
// Build option: define MB_POLL_RETRY_EN to retry a failed entry up to
// MAX_RETRY times before reporting it as failed.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   poll_en                      level enable for continuous polling
//   cfg_we/idx/valid/fun/addr/num poll-table write port
//   tx_en_pulse                  one-cycle frame launch
//   mb_fun/mb_addr/mb_num        latched request fields, valid the cycle
//                                before tx_en_pulse and held until the
//                                next entry is selected
//   tx_done, rx_done, rx_ok      transmitter / receiver completion
//   busy                         scheduler not idle
//   cur_idx                      entry in flight
//   entry_ok / entry_fail        one-cycle outcome pulses
//   fail_cnt                     saturating count of entry_fail pulses
// All outputs are flop outputs; event pulses appear one cycle after the
// state-machine event that causes them.
// -----------------------------------------------------------------------------
module mb_rtu_poll_sched
    import mb_rtu_pkg::*;
#(
    parameter int          ENTRIES        = 4,
    parameter int          IDX_W          = 2,
    parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             poll_en,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic             cfg_valid,
    input  logic [7:0]       cfg_fun,
    input  logic [15:0]      cfg_addr,
    input  logic [15:0]      cfg_num,
    output logic             tx_en_pulse,
    output logic [7:0]       mb_fun,
    output logic [15:0]      mb_addr,
    output logic [15:0]      mb_num,
    input  logic             tx_done,
    input  logic             rx_done,
    input  logic             rx_ok,
    output logic             busy,
    output logic [IDX_W-1:0] cur_idx,
    output logic             entry_ok,
    output logic             entry_fail,
    output logic [15:0]      fail_cnt
);

    poll_state_e        state_r, state_nxt_s;
    logic [31:0]        cnt_r;
    logic [IDX_W-1:0]   ptr_r, cur_idx_r, sel_idx_s;
    logic [ENTRIES-1:0] valid_vec_s;
    logic [7:0]         rd_fun_s, mb_fun_r;
    logic [15:0]        rd_addr_s, rd_num_s, mb_addr_r, mb_num_r, fail_cnt_r;
    logic               tx_en_r, entry_ok_r, entry_fail_r, busy_r;
    logic               ld_entry_s, ok_s, fail_evt_s, gap_end_s;
    logic               retry_now_s, retry_pend_s, retry_go_s;

    mb_poll_table #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_valid (cfg_valid),
        .cfg_fun   (cfg_fun),
        .cfg_addr  (cfg_addr),
        .cfg_num   (cfg_num),
        .rd_idx    (sel_idx_s),
        .rd_fun    (rd_fun_s),
        .rd_addr   (rd_addr_s),
        .rd_num    (rd_num_s),
        .valid_vec (valid_vec_s)
    );

    // SELECT scans ptr, ptr+1, ... using the low bits of the state counter
    assign sel_idx_s  = ptr_r + cnt_r[IDX_W-1:0];
    // A pending retry relaunches only while polling is still enabled
    assign retry_go_s = retry_pend_s & poll_en;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and event decode
    always_comb begin
        state_nxt_s = state_r;
        ld_entry_s  = 1'b0;
        ok_s        = 1'b0;
        fail_evt_s  = 1'b0;
        gap_end_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (poll_en) begin
                    state_nxt_s = ST_SELECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (valid_vec_s[sel_idx_s]) begin
                    ld_entry_s  = 1'b1;
                    state_nxt_s = ST_LAUNCH;
                end else if (cnt_r == 32'(ENTRIES - 1)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SELECT;
                end
            end
            ST_LAUNCH: begin
                state_nxt_s = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_done) begin
                    state_nxt_s = ST_WAIT_RX;
                end else if (cnt_r == TIMEOUT_CYCLES - 32'd1) begin
                    fail_evt_s  = 1'b1;
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_WAIT_TX;
                end
            end
            ST_WAIT_RX: begin
                // A response arriving on the timeout cycle takes priority
                if (rx_done) begin
                    ok_s        = rx_ok;
                    fail_evt_s  = ~rx_ok;
                    state_nxt_s = ST_GAP;
                end else if (cnt_r == TIMEOUT_CYCLES - 32'd1) begin
                    fail_evt_s  = 1'b1;
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_WAIT_RX;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_CYCLES - 32'd1) begin
                    gap_end_s = 1'b1;
                    if (retry_go_s) begin
                        state_nxt_s = ST_LAUNCH;
                    end else if (poll_en) begin
                        state_nxt_s = ST_SELECT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Shared timer / gap / scan counter, cleared on every state entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 32'd0;
        end else if (state_nxt_s != state_r) begin
            cnt_r <= 32'd0;
        end else begin
            cnt_r <= cnt_r + 32'd1;
        end
    end

`ifdef MB_POLL_RETRY_EN
    logic [7:0] retry_r;
    logic       retry_pend_r;

    assign retry_now_s  = fail_evt_s & (retry_r < 8'(MAX_RETRY));
    assign retry_pend_s = retry_pend_r;

    // Per-transaction retry bookkeeping; cleared once the entry is left
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_r      <= 8'd0;
            retry_pend_r <= 1'b0;
        end else if (retry_now_s) begin
            retry_r      <= retry_r + 8'd1;
            retry_pend_r <= 1'b1;
        end else if (ok_s || (gap_end_s && !retry_go_s)) begin
            retry_r      <= 8'd0;
            retry_pend_r <= 1'b0;
        end else if (gap_end_s) begin
            retry_pend_r <= 1'b0;
        end
    end
`else
    assign retry_now_s  = 1'b0;
    assign retry_pend_s = 1'b0;
`endif

    // Registered outputs, request latch and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_en_r      <= 1'b0;
            entry_ok_r   <= 1'b0;
            entry_fail_r <= 1'b0;
            busy_r       <= 1'b0;
            fail_cnt_r   <= 16'h0000;
            mb_fun_r     <= 8'h00;
            mb_addr_r    <= 16'h0000;
            mb_num_r     <= 16'h0000;
            cur_idx_r    <= '0;
            ptr_r        <= '0;
        end else begin
            tx_en_r      <= (state_r == ST_LAUNCH);
            entry_ok_r   <= ok_s;
            entry_fail_r <= fail_evt_s & ~retry_now_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
            if (fail_evt_s && !retry_now_s) begin
                fail_cnt_r <= sat_inc16(fail_cnt_r);
            end
            if (ld_entry_s) begin
                mb_fun_r  <= rd_fun_s;
                mb_addr_r <= rd_addr_s;
                mb_num_r  <= rd_num_s;
                cur_idx_r <= sel_idx_s;
            end
            if (gap_end_s && !retry_go_s) begin
                ptr_r <= cur_idx_r + IDX_W'(1);
            end
        end
    end

    assign tx_en_pulse = tx_en_r;
    assign entry_ok    = entry_ok_r;
    assign entry_fail  = entry_fail_r;
    assign busy        = busy_r;
    assign fail_cnt    = fail_cnt_r;
    assign mb_fun      = mb_fun_r;
    assign mb_addr     = mb_addr_r;
    assign mb_num      = mb_num_r;
    assign cur_idx     = cur_idx_r;

endmodule
